// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants for operand forwarding
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority forwarding comparator for one EX operand
module fwd_select
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::REG_ADDR_W
) (
  input  logic [W-1:0] rs,
  input  logic         use_rs,
  input  logic [W-1:0] ex_rd,
  input  logic         ex_we,
  input  logic [W-1:0] mem_rd,
  input  logic         mem_we,
  output logic [1:0]   sel
);
  logic ex_hit, mem_hit;
  always_comb begin
    ex_hit  = use_rs && ex_we && ex_rd != '0 && ex_rd == rs;
    mem_hit = use_rs && mem_we && mem_rd != '0 && mem_rd == rs;
    sel     = ex_hit ? FWD_MEM : mem_hit ? FWD_WB : FWD_REGFILE;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding selects, load-use stall and bubble control for the 5-stage pipeline
module fwd_hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int SEL_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_bubble,
  output logic [SEL_W-1:0]      fwd_a,
  output logic [SEL_W-1:0]      fwd_b,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd
);
  logic ex_we, ex_mr, mem_we;
  logic [1:0] sel_a, sel_b;
  fwd_select #(.W(REG_ADDR_W)) u_sel_a (
    .rs(id_rs1), .use_rs(id_use_rs1), .ex_rd(ex_rd), .ex_we(ex_we),
    .mem_rd(mem_rd), .mem_we(mem_we), .sel(sel_a)
  );
  fwd_select #(.W(REG_ADDR_W)) u_sel_b (
    .rs(id_rs2), .use_rs(id_use_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
    .mem_rd(mem_rd), .mem_we(mem_we), .sel(sel_b)
  );
  always_comb begin
    stall = id_valid && !flush && ex_mr && ex_rd != '0 &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    ex_bubble = stall || flush || !id_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd  <= '0;
      ex_we  <= 1'b0;
      ex_mr  <= 1'b0;
      mem_rd <= '0;
      mem_we <= 1'b0;
      wb_rd  <= '0;
      fwd_a  <= '0;
      fwd_b  <= '0;
    end else begin
      ex_rd  <= ex_bubble ? '0 : id_rd;
      ex_we  <= !ex_bubble && id_reg_write;
      ex_mr  <= !ex_bubble && id_mem_read;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      wb_rd  <= mem_rd;
      fwd_a  <= ex_bubble ? '0 : sel_a;
      fwd_b  <= ex_bubble ? '0 : sel_b;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenario checks for forwarding, stall and flush behaviour
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
  logic stall, ex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  int errs = 0;
  int checks = 0;
  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .ex_bubble(ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd)
  );
  always #5 clk = ~clk;
  task automatic put(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                     input logic u2, input logic [4:0] rd, input logic we, input logic mr, input logic fl);
    @(negedge clk);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = we; id_mem_read = mr; flush = fl;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drain;
    for (int i = 0; i < 3; i++) begin
      put(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask
  task automatic test_reset;
    #2;
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (ex_bubble !== 1'b1) begin errs++; $display("FAIL reset_bubble got=%0b exp=1", ex_bubble); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errs++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    checks++; if ({ex_rd, mem_rd, wb_rd} !== 15'd0) begin errs++; $display("FAIL reset_slots got=%h exp=0", {ex_rd, mem_rd, wb_rd}); end
    @(negedge clk); rst_n = 1'b1;
    drain();
  endtask
  task automatic test_alu_alu;
    put(1, 1, 2, 1, 1, 5, 1, 0, 0);
    checks++; if (ex_bubble !== 1'b0) begin errs++; $display("FAIL alu_bubble got=%0b exp=0", ex_bubble); end
    tick();
    put(1, 5, 7, 1, 1, 6, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL alu_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL alu_fwd_a got=%b exp=10", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errs++; $display("FAIL alu_fwd_b got=%b exp=00", fwd_b); end
    checks++; if ({ex_rd, mem_rd} !== {5'd6, 5'd5}) begin errs++; $display("FAIL alu_slots got=%0d,%0d exp=6,5", ex_rd, mem_rd); end
    drain();
  endtask
  task automatic test_dist2;
    put(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
    put(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    put(1, 1, 5, 1, 1, 8, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL d2_stall got=%0b exp=0", stall); end
    tick();
    checks++; if (fwd_b !== 2'b01) begin errs++; $display("FAIL d2_fwd_b got=%b exp=01", fwd_b); end
    checks++; if (fwd_a !== 2'b00) begin errs++; $display("FAIL d2_fwd_a got=%b exp=00", fwd_a); end
    checks++; if (wb_rd !== 5'd5) begin errs++; $display("FAIL d2_wb_rd got=%0d exp=5", wb_rd); end
    drain();
  endtask
  task automatic test_double;
    put(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
    put(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
    put(1, 5, 0, 1, 0, 4, 1, 0, 0); tick();
    checks++; if (fwd_a !== 2'b10) begin errs++; $display("FAIL dbl_fwd_a got=%b exp=10", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errs++; $display("FAIL dbl_fwd_b got=%b exp=00", fwd_b); end
    drain();
  endtask
  task automatic test_load_use;
    put(1, 2, 0, 1, 0, 9, 1, 1, 0); tick();
    put(1, 9, 9, 1, 1, 10, 1, 0, 0);
    checks++; if (stall !== 1'b1) begin errs++; $display("FAIL lu_stall got=%0b exp=1", stall); end
    checks++; if (ex_bubble !== 1'b1) begin errs++; $display("FAIL lu_bubble got=%0b exp=1", ex_bubble); end
    tick();
    checks++; if ({ex_rd, mem_rd} !== {5'd0, 5'd9}) begin errs++; $display("FAIL lu_slots got=%0d,%0d exp=0,9", ex_rd, mem_rd); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errs++; $display("FAIL lu_bubble_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_stall2 got=%0b exp=0", stall); end
    checks++; if (ex_bubble !== 1'b0) begin errs++; $display("FAIL lu_bubble2 got=%0b exp=0", ex_bubble); end
    tick();
    checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin errs++; $display("FAIL lu_fwd got=%b exp=0101", {fwd_a, fwd_b}); end
    checks++; if (ex_rd !== 5'd10) begin errs++; $display("FAIL lu_ex_rd got=%0d exp=10", ex_rd); end
    drain();
  endtask
  task automatic test_x0;
    put(1, 1, 2, 1, 1, 0, 1, 0, 0); tick();
    put(1, 0, 0, 1, 1, 4, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL x0_stall got=%0b exp=0", stall); end
    tick();
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errs++; $display("FAIL x0_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    put(1, 2, 0, 1, 0, 0, 1, 1, 0); tick();
    put(1, 0, 0, 1, 1, 4, 1, 0, 0);
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL x0_load_stall got=%0b exp=0", stall); end
    drain();
  endtask
  task automatic test_flush;
    put(1, 2, 0, 1, 0, 9, 1, 1, 0); tick();
    put(1, 9, 9, 1, 1, 10, 1, 0, 1);
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL fl_stall got=%0b exp=0", stall); end
    checks++; if (ex_bubble !== 1'b1) begin errs++; $display("FAIL fl_bubble got=%0b exp=1", ex_bubble); end
    tick();
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errs++; $display("FAIL fl_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    checks++; if (ex_rd !== 5'd0) begin errs++; $display("FAIL fl_ex_rd got=%0d exp=0", ex_rd); end
    drain();
  endtask
  task automatic test_reset_mid;
    put(1, 2, 0, 1, 0, 9, 1, 1, 0); tick();
    put(1, 9, 0, 1, 0, 10, 1, 0, 0);
    checks++; if (stall !== 1'b1) begin errs++; $display("FAIL rm_pre_stall got=%0b exp=1", stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL rm_stall got=%0b exp=0", stall); end
    checks++; if ({ex_rd, mem_rd, wb_rd} !== 15'd0) begin errs++; $display("FAIL rm_slots got=%h exp=0", {ex_rd, mem_rd, wb_rd}); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL rm_post_stall got=%0b exp=0", stall); end
    tick();
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errs++; $display("FAIL rm_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    checks++; if (ex_rd !== 5'd10) begin errs++; $display("FAIL rm_ex_rd got=%0d exp=10", ex_rd); end
    drain();
  endtask
  initial begin
    test_reset();
    test_alu_alu();
    test_dist2();
    test_double();
    test_load_use();
    test_x0();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Data-hazard controller for the 5-stage integer pipeline.
- Tracks destination-register state for the ID/EX, EX/MEM and MEM/WB slots.
- Produces registered 2-bit operand-select codes for the two EX-stage operand 3:1 muxes.
- Generates load-use stall and bubble-insertion control, and honours branch flushes from EX.

Parameters:
- REG_ADDR_W, 5: register-index width.
- SEL_W, 2: operand-select code width, fixed at 2.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_rs1  in  REG_ADDR_W  source register 1 of ID instruction
- id_rs2  in  REG_ADDR_W  source register 2 of ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd  in  REG_ADDR_W  destination of ID instruction
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch/jump resolved taken in EX; kill ID instruction
- stall  out  1  hold PC and IF/ID (combinational)
- ex_bubble  out  1  ID/EX loads a NOP this edge (combinational)
- fwd_a  out  SEL_W  EX operand-A select (registered)
- fwd_b  out  SEL_W  EX operand-B select (registered)
- ex_rd, mem_rd, wb_rd  out  REG_ADDR_W  tracked destinations (debug/observability)

Behaviour:
- Select encoding:
  - 2'b00: register-file value.
  - 2'b01: WB result.
  - 2'b10: EX/MEM ALU result.
  - 2'b11: never driven.
- Internal slots ex_*, mem_*, wb_* each hold rd, reg_write and mem_read. They shift every rising clk edge (ex→mem→wb); the ex slot loads from id_* or a bubble.
- Bubble: rd=0, reg_write=0, mem_read=0. It is loaded when id_valid=0, stall=1 or flush=1.
- stall = id_valid & ~flush & ex_mem_read & (ex_rd≠0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- ex_bubble = stall | flush | ~id_valid.
- fwd_a next value, computed in ID and registered at the edge the instruction enters EX:
  - 2'b10 if ex_reg_write & ex_rd≠0 & ex_rd==id_rs1 & id_use_rs1.
  - else 2'b01 if mem_reg_write & mem_rd≠0 & mem_rd==id_rs1 & id_use_rs1.
  - else 2'b00.
- fwd_b is identical using rs2/use_rs2.
- The EX/MEM match has priority over MEM/WB, so the youngest producer wins.
- When a bubble loads (stall/flush/invalid), fwd_a and fwd_b register 2'b00.
- Register x0 is never forwarded and never stalls.
- The MEM/WB-slot writer at time of ID read is not forwarded. The register file provides read-during-write bypass.
- Latency:
  - stall and ex_bubble are same-cycle combinational from inputs and slot state.
  - fwd_* are valid the full cycle the instruction occupies EX.
- Load-use sequence:
  - Exactly one stall cycle.
  - The dependent instruction then sees the load in the mem slot and registers 2'b01.
- flush and stall together: flush wins, stall=0, bubble loaded.
- Reset (async, rst_n low): all slots become bubbles, fwd_a=fwd_b=2'b00, stall=0. ex_bubble=1 while id_valid=0.
- Deassertion mid-pipeline restarts from the empty state. No partial state survives.

Decomposition:
- Shared package cpu_pkg holds:
  - Constants FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The REG_ADDR_W default.
- A natural sub-module is fwd_select: a combinational priority comparator for one operand. It is instantiated twice (rs1, rs2) and keeps the select logic symmetric.

Test Plan:
- ALU-ALU back-to-back: `add x5,…` then `sub x6,x5,x7` → fwd_a=2'b10 in sub's EX cycle, fwd_b=2'b00, stall never 1.
- Distance-2: `add x5,…`, unrelated, then `or x8,x1,x5` → fwd_b=2'b01 in the or's EX cycle.
- Double producer: `add x5`, `add x5`, `use x5` → fwd_a=2'b10 (youngest wins).
- Load-use: `lw x9,0(x2)` then `add x10,x9,x9`:
  - stall=1 and ex_bubble=1 for exactly one cycle.
  - Next cycle the add enters EX with fwd_a=fwd_b=2'b01.
- x0 and flush cases:
  - `add x0,…` then `use x0` → fwd=2'b00.
  - Load-use with flush=1 in the same cycle → stall=0, ex_bubble=1, fwd=2'b00.
- Reset mid-operation: assert rst_n=0 with a load in ex slot → stall drops immediately. After release, a dependent instruction gets 2'b00 and no stall.
